msc_alu_seq: RTL

Parametrised sequential ALU, the next generation of the msc16 core ALU, for WIDTH-bit msc cores.
- Operands enter and results leave over valid/ready handshakes.
- Results carry a flag vector (Z/N/C/V/ERR), so the core no longer derives flags itself in its result state.
- Adds arithmetic shift, add-with-carry, compare, and an optional iterative multiplier.

---
 rtl/msc_alu_seq.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/msc_alu_seq.sv
// Sequential ALU with valid/ready operand and result handshakes and a Z/N/C/V/ERR flag vector.
// Define MSC_ALU_MUL_EN to build the iterative shift-add MUL/MULH unit; otherwise opcodes A/B are illegal.
module msc_alu_seq #(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [4:0]       out_flags,
  output logic             out_wb,
  output logic             busy
);

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_LSH  = 4'h5;
  localparam logic [3:0] OP_RSH  = 4'h6;
  localparam logic [3:0] OP_ASR  = 4'h7;
  localparam logic [3:0] OP_CMP  = 4'h8;
  localparam logic [3:0] OP_ADC  = 4'h9;
`ifdef MSC_ALU_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'hA;
  localparam logic [3:0] OP_MULH = 4'hB;
`endif

  logic [SHAMT_W-1:0]    shamt;
  logic                  add_cin;
  logic [WIDTH:0]        sum;
  logic [WIDTH:0]        diff;
  logic [WIDTH:0]        lsh;
  logic [WIDTH:0]        rsh;
  logic signed [WIDTH:0] asr;
  logic [WIDTH-1:0]      alu_res;
  logic                  alu_c;
  logic                  alu_v;
  logic                  alu_err;
  logic                  alu_wb;
  logic                  is_mul;
  logic [4:0]            alu_flags;
  logic                  idle;
  logic                  out_free;
  logic                  accept;

  // Shifts carry one extra bit so the last bit shifted out lands in the carry position.
  assign shamt   = in_b[SHAMT_W-1:0];
  assign add_cin = (in_op == OP_ADC) ? in_cin : 1'b0;
  assign sum     = {1'b0, in_a} + {1'b0, in_b} + (WIDTH+1)'(add_cin);
  assign diff    = {1'b0, in_a} - {1'b0, in_b};
  assign lsh     = {1'b0, in_a} << shamt;
  assign rsh     = {in_a, 1'b0} >> shamt;
  assign asr     = $signed({in_a, 1'b0}) >>> shamt;

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_err = 1'b0;
    alu_wb  = 1'b1;
    is_mul  = 1'b0;
    case (in_op)
      OP_ADD, OP_ADC: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (sum[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        alu_res = diff[WIDTH-1:0];
        alu_c   = diff[WIDTH];
        alu_v   = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (diff[WIDTH-1] != in_a[WIDTH-1]);
        alu_wb  = (in_op != OP_CMP);
      end
      OP_AND: alu_res = in_a & in_b;
      OP_OR:  alu_res = in_a | in_b;
      OP_XOR: alu_res = in_a ^ in_b;
      OP_LSH: begin
        alu_res = lsh[WIDTH-1:0];
        alu_c   = lsh[WIDTH];
      end
      OP_RSH: begin
        alu_res = rsh[WIDTH:1];
        alu_c   = rsh[0];
      end
      OP_ASR: begin
        alu_res = asr[WIDTH:1];
        alu_c   = asr[0];
      end
`ifdef MSC_ALU_MUL_EN
      OP_MUL, OP_MULH: is_mul = 1'b1;
`endif
      default: begin
        alu_err = 1'b1;
        alu_wb  = 1'b0;
      end
    endcase
  end

  assign alu_flags = alu_err ? 5'b10000
                             : {1'b0, alu_v, alu_c, alu_res[WIDTH-1], (alu_res == '0)};

`ifdef MSC_ALU_MUL_EN
  typedef enum logic {IDLE, MUL} state_t;

  localparam logic [SHAMT_W:0] CNT_LAST = (SHAMT_W+1)'(WIDTH - 1);
  localparam logic [SHAMT_W:0] CNT_END  = (SHAMT_W+1)'(WIDTH);

  state_t             state;
  logic [WIDTH-1:0]   mul_a;
  logic               mul_high;
  logic [2*WIDTH-1:0] acc;
  logic [SHAMT_W:0]   cnt;
  logic [WIDTH:0]     acc_add;
  logic [2*WIDTH-1:0] acc_step;
  logic [2*WIDTH-1:0] mul_final;
  logic               mul_done;
  logic [WIDTH-1:0]   mul_res;
  logic [4:0]         mul_flags;

  // Accumulator low half starts as the multiplier and is consumed LSB first as the product shifts in.
  assign acc_add   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mul_a} : '0);
  assign acc_step  = {acc_add, acc[WIDTH-1:1]};
  assign mul_final = (cnt == CNT_END) ? acc : acc_step;
  assign mul_done  = (state == MUL) && ((cnt == CNT_LAST) || (cnt == CNT_END));
  assign mul_res   = mul_high ? mul_final[2*WIDTH-1:WIDTH] : mul_final[WIDTH-1:0];
  assign mul_flags = {2'b00, mul_high && (mul_final[2*WIDTH-1:WIDTH] != '0),
                      mul_res[WIDTH-1], (mul_res == '0)};
  assign idle      = (state == IDLE);
`else
  assign idle      = 1'b1;
  assign busy      = 1'b0;
`endif

  assign out_free = !out_valid || out_ready;
  assign in_ready = idle && out_free;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid  <= 1'b0;
      out_result <= '0;
      out_flags  <= '0;
      out_wb     <= 1'b0;
`ifdef MSC_ALU_MUL_EN
      state      <= IDLE;
      busy       <= 1'b0;
      mul_a      <= '0;
      mul_high   <= 1'b0;
      acc        <= '0;
      cnt        <= '0;
`endif
    end else begin
      if (accept && !is_mul) begin
        out_valid  <= 1'b1;
        out_result <= alu_res;
        out_flags  <= alu_flags;
        out_wb     <= alu_wb;
      end
`ifdef MSC_ALU_MUL_EN
      else if (mul_done && out_free) begin
        out_valid  <= 1'b1;
        out_result <= mul_res;
        out_flags  <= mul_flags;
        out_wb     <= 1'b1;
      end
`endif
      else if (out_ready) begin
        out_valid <= 1'b0;
      end
`ifdef MSC_ALU_MUL_EN
      case (state)
        IDLE: begin
          if (accept && is_mul) begin
            state    <= MUL;
            busy     <= 1'b1;
            mul_a    <= in_a;
            mul_high <= (in_op == OP_MULH);
            acc      <= {{WIDTH{1'b0}}, in_b};
            cnt      <= '0;
          end
        end
        MUL: begin
          // A finished product parks in the accumulator until the output register is free.
          if (cnt != CNT_END) begin
            acc <= acc_step;
            cnt <= cnt + 1'b1;
          end
          if (mul_done && out_free) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
`endif
    end
  end

endmodule
